// File: rtl/rr_arbiter_32.sv
// Round-robin arbiter for up to 32 requesters with registered index and one-hot
// grants, hold-until-release semantics and a watchdog that forces release.
module rr_arbiter_32 #(
  parameter int N        = 32,
  parameter int IDXW     = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic [N-1:0]    gnt_onehot,
  output logic            forced
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0]      HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0]      HOLD_SAT  = 8'(MAX_HOLD);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(N - 1);
  localparam logic [N-1:0]    ONE       = {{(N-1){1'b0}}, 1'b1};

  state_t          state, state_next;
  logic [IDXW-1:0] ptr, ptr_next;
  logic [7:0]      hold_cnt, hold_cnt_next;
  logic            gnt_valid_next, forced_next;
  logic [IDXW-1:0] gnt_idx_next;
  logic [N-1:0]    gnt_onehot_next;

  logic            found_hi;
  logic [IDXW-1:0] pick_hi, pick_all;
  logic [N-1:0]    oh_hi, oh_all;
  logic            still_req, timeout, release_grant;

  // Lowest set request at or above ptr wins; otherwise the lowest set request overall.
  always_comb begin
    found_hi = 1'b0;
    pick_hi  = '0;
    pick_all = '0;
    oh_hi    = '0;
    oh_all   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        pick_all = IDXW'(j);
        oh_all   = ONE << j;
      end
      if (req[j] && (j >= int'(ptr))) begin
        found_hi = 1'b1;
        pick_hi  = IDXW'(j);
        oh_hi    = ONE << j;
      end
    end
  end

  assign still_req     = |(req & gnt_onehot);
  assign timeout       = (hold_cnt == HOLD_LAST);
  assign release_grant = done || !still_req || timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      forced     <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      hold_cnt   <= hold_cnt_next;
      gnt_valid  <= gnt_valid_next;
      gnt_idx    <= gnt_idx_next;
      gnt_onehot <= gnt_onehot_next;
      forced     <= forced_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = GRANT;
      GRANT:   if (release_grant) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A release always drops to IDLE, which guarantees a bubble between grants.
  always_comb begin
    ptr_next        = ptr;
    hold_cnt_next   = hold_cnt;
    gnt_valid_next  = 1'b0;
    gnt_idx_next    = '0;
    gnt_onehot_next = '0;
    forced_next     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_valid_next  = 1'b1;
          gnt_idx_next    = found_hi ? pick_hi : pick_all;
          gnt_onehot_next = found_hi ? oh_hi : oh_all;
          hold_cnt_next   = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          ptr_next      = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
          hold_cnt_next = '0;
          forced_next   = timeout && !done && still_req;
        end else begin
          gnt_valid_next  = 1'b1;
          gnt_idx_next    = gnt_idx;
          gnt_onehot_next = gnt_onehot;
          hold_cnt_next   = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

endmodule
